// File: rtl/key_pkg.sv
// Shared types and sizing helpers for the push-button debounce block.
package key_pkg;

   // Per-channel debounce state
   typedef enum logic [1:0] {
      REL     = 2'd0,  // stable released
      ARM_PRS = 2'd1,  // candidate press, counting stable ticks
      PRS     = 2'd2,  // stable pressed
      ARM_REL = 2'd3   // candidate release, counting stable ticks
   } key_state_t;

   // Default operating point
   localparam int DEF_NUM_KEYS       = 4;
   localparam int DEF_CLK_HZ         = 50_000_000;
   localparam int DEF_TICK_HZ        = 1000;
   localparam int DEF_DEBOUNCE_TICKS = 20;

   // Clocks per debounce sample tick
   function automatic int calc_period(input int clk_hz, input int tick_hz);
      return clk_hz / tick_hz;
   endfunction

   // Bits needed to count 0..n-1 (at least one bit)
   function automatic int width_for(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Derived sizes for the default operating point
   localparam int DEF_PERIOD = calc_period(DEF_CLK_HZ, DEF_TICK_HZ);
   localparam int DEF_PRE_W  = width_for(DEF_PERIOD);
   localparam int DEF_CNT_W  = width_for(DEF_DEBOUNCE_TICKS);

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability FSM and tick counter.
// Produces a registered clean level plus press/release strobes that are
// asserted in exactly the cycle the level changes.
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
)
(
   input  logic clk,
   input  logic reset_n,
   input  logic tick,
   input  logic key_raw,
   output logic key_out,
   output logic key_press,
   output logic key_release
);

   localparam int                CNT_W    = width_for(DEBOUNCE_TICKS);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

   logic             sync1;
   logic             sync2;
   key_state_t       state;
   key_state_t       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             out_nxt;
   logic             press_nxt;
   logic             release_nxt;

   // Bring the asynchronous pin into the clk domain; idle level is released (1)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
      end
   end

   // State, counter and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= REL;
         cnt         <= '0;
         key_out     <= 1'b1;
         key_press   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         key_out     <= out_nxt;
         key_press   <= press_nxt;
         key_release <= release_nxt;
      end
   end

   // Next-state logic; a revert to the stable level takes priority over a tick
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      out_nxt     = key_out;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      case (state)
         REL: begin
            if (!sync2) begin
               state_nxt = ARM_PRS;
               cnt_nxt   = '0;
            end
         end
         ARM_PRS: begin
            if (sync2) begin
               state_nxt = REL;
               cnt_nxt   = '0;
            end else if (tick) begin
               if (cnt == CNT_LAST) begin
                  state_nxt = PRS;
                  cnt_nxt   = '0;
                  out_nxt   = 1'b0;
                  press_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         PRS: begin
            if (sync2) begin
               state_nxt = ARM_REL;
               cnt_nxt   = '0;
            end
         end
         ARM_REL: begin
            if (!sync2) begin
               state_nxt = PRS;
               cnt_nxt   = '0;
            end else if (tick) begin
               if (cnt == CNT_LAST) begin
                  state_nxt   = REL;
                  cnt_nxt     = '0;
                  out_nxt     = 1'b1;
                  release_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end
         default: begin
            state_nxt = REL;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioning: shared sample-tick prescaler feeding one
// independent debounce channel per key. key_out goes straight to the PIO.
module key_debounce
   import key_pkg::*;
#(
   parameter int NUM_KEYS       = DEF_NUM_KEYS,
   parameter int CLK_HZ         = DEF_CLK_HZ,
   parameter int TICK_HZ        = DEF_TICK_HZ,
   parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
)
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_KEYS-1:0] key_raw,
   output logic [NUM_KEYS-1:0] key_out,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release
);

   localparam int               P        = calc_period(CLK_HZ, TICK_HZ);
   localparam int               PRE_W    = width_for(P);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(P - 1);

   logic [PRE_W-1:0] pre_cnt;
   logic             tick;

   // Tick is the single cycle in which the prescaler sits at its last count
   assign tick = (pre_cnt == PRE_LAST);

   // Free-running prescaler 0..P-1, wrapping on the tick edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
      ) u_ch (
         .clk         (clk),
         .reset_n     (reset_n),
         .tick        (tick),
         .key_raw     (key_raw[i]),
         .key_out     (key_out[i]),
         .key_press   (key_press[i]),
         .key_release (key_release[i])
      );
   end

endmodule

// File: tb/tb_key_debounce.sv
// Directed testbench for key_debounce with P=10, DEBOUNCE_TICKS=4.
module tb_key_debounce;

   logic       clk;
   logic       reset_n;
   logic [3:0] key_raw;
   logic [3:0] key_out;
   logic [3:0] key_press;
   logic [3:0] key_release;

   int n_assert;
   int n_fail;

   // Results of the most recent wait_level call
   int         lat;
   int         n_prs;
   int         n_rel;
   logic [3:0] prs_at;
   logic [3:0] rel_at;
   logic [3:0] out_at;

   key_debounce #(
      .NUM_KEYS       (4),
      .CLK_HZ         (1000),
      .TICK_HZ        (100),
      .DEBOUNCE_TICKS (4)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .key_raw     (key_raw),
      .key_out     (key_out),
      .key_press   (key_press),
      .key_release (key_release)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Step cycles; each call ends 1 time unit after a rising edge
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Wait (bounded) for key_out[idx] to reach val. Edge 1 is the first edge
   // sampling the new raw level; lat is counted from that edge, so a channel
   // output changing at edge n gives lat = n-1. lat = -1 on timeout.
   task automatic wait_level(input int idx, input logic val);
      lat    = -1;
      n_prs  = 0;
      n_rel  = 0;
      prs_at = 'x;
      rel_at = 'x;
      out_at = 'x;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk);
         #1;
         if (key_press != 4'h0) n_prs++;
         if (key_release != 4'h0) n_rel++;
         if (key_out[idx] === val) begin
            lat    = c - 1;
            prs_at = key_press;
            rel_at = key_release;
            out_at = key_out;
            break;
         end
      end
   endtask

   task automatic test_reset();
      key_raw = 4'h0;
      reset_n = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         n_assert++;
         if (key_out !== 4'hF || key_press !== 4'h0 || key_release !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_hold: out=%h press=%h rel=%h, required out=f press=0 rel=0",
                     key_out, key_press, key_release);
         end
      end
      reset_n = 1'b1;
      wait_level(0, 1'b0);
      // prescaler restarts at 0: arm at edge 3, ticks consumed at 10,20,30,40
      n_assert++;
      if (lat !== 39) begin
         n_fail++;
         $display("FAIL reset_latency: got %0d, required 39", lat);
      end
      n_assert++;
      if (out_at !== 4'h0 || prs_at !== 4'hF || n_prs !== 1) begin
         n_fail++;
         $display("FAIL reset_press: out=%h press=%h strobes=%0d, required out=0 press=f strobes=1",
                  out_at, prs_at, n_prs);
      end
      idle(1);
      n_assert++;
      if (key_press !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_press_width: press=%h, required 0", key_press);
      end
      key_raw = 4'hF;
      idle(50);
      n_assert++;
      if (key_out !== 4'hF) begin
         n_fail++;
         $display("FAIL reset_all_released: out=%h, required f", key_out);
      end
   endtask

   task automatic test_press_key0();
      key_raw = 4'hE;
      wait_level(0, 1'b0);
      n_assert++;
      if (lat < 33 || lat > 42) begin
         n_fail++;
         $display("FAIL press0_latency: got %0d, required 33..42", lat);
      end
      n_assert++;
      if (out_at !== 4'hE || prs_at !== 4'h1 || n_prs !== 1 || n_rel !== 0) begin
         n_fail++;
         $display("FAIL press0_strobe: out=%h press=%h prs=%0d rel=%0d, required out=e press=1 prs=1 rel=0",
                  out_at, prs_at, n_prs, n_rel);
      end
      idle(1);
      n_assert++;
      if (key_press !== 4'h0 || key_out !== 4'hE) begin
         n_fail++;
         $display("FAIL press0_after: out=%h press=%h, required out=e press=0", key_out, key_press);
      end
      key_raw = 4'hF;
      idle(50);
   endtask

   task automatic test_bounce_key1();
      int bad;
      bad = 0;
      key_raw = 4'hF;
      for (int c = 0; c < 100; c++) begin
         if (c % 5 == 0) key_raw[1] = ~key_raw[1];
         @(posedge clk);
         #1;
         if (key_out[1] !== 1'b1 || key_press !== 4'h0 || key_release !== 4'h0) bad++;
      end
      n_assert++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL bounce_hold: %0d bad cycles, required 0", bad);
      end
      key_raw[1] = 1'b0;
      wait_level(1, 1'b0);
      n_assert++;
      if (lat < 33 || lat > 42) begin
         n_fail++;
         $display("FAIL bounce_latency: got %0d, required 33..42", lat);
      end
      n_assert++;
      if (prs_at !== 4'h2 || n_prs !== 1 || out_at !== 4'hD) begin
         n_fail++;
         $display("FAIL bounce_press: out=%h press=%h prs=%0d, required out=d press=2 prs=1",
                  out_at, prs_at, n_prs);
      end
      key_raw = 4'hF;
      idle(50);
   endtask

   task automatic test_glitch_key2();
      int bad;
      bad = 0;
      key_raw = 4'hB;
      for (int c = 0; c < 85; c++) begin
         if (c == 25) key_raw = 4'hF;
         @(posedge clk);
         #1;
         if (key_out !== 4'hF || key_press !== 4'h0 || key_release !== 4'h0) bad++;
      end
      n_assert++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL glitch: %0d bad cycles, required 0", bad);
      end
   endtask

   task automatic test_release_key3();
      key_raw = 4'h7;
      wait_level(3, 1'b0);
      n_assert++;
      if (out_at !== 4'h7 || prs_at !== 4'h8) begin
         n_fail++;
         $display("FAIL rel3_press: out=%h press=%h, required out=7 press=8", out_at, prs_at);
      end
      idle(5);
      key_raw = 4'hF;
      wait_level(3, 1'b1);
      n_assert++;
      if (lat < 33 || lat > 42) begin
         n_fail++;
         $display("FAIL rel3_latency: got %0d, required 33..42", lat);
      end
      n_assert++;
      if (out_at !== 4'hF || rel_at !== 4'h8 || n_rel !== 1 || n_prs !== 0) begin
         n_fail++;
         $display("FAIL rel3_strobe: out=%h rel=%h rel_n=%0d prs_n=%0d, required out=f rel=8 rel_n=1 prs_n=0",
                  out_at, rel_at, n_rel, n_prs);
      end
      idle(1);
      n_assert++;
      if (key_release !== 4'h0) begin
         n_fail++;
         $display("FAIL rel3_width: rel=%h, required 0", key_release);
      end
   endtask

   task automatic test_reset_mid();
      int bad_pre;
      int bad_rst;
      int bad_post;
      bad_pre  = 0;
      bad_rst  = 0;
      bad_post = 0;
      key_raw = 4'hE;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (key_out !== 4'hF || key_press !== 4'h0 || key_release !== 4'h0) bad_pre++;
      end
      reset_n = 1'b0;
      #1;
      key_raw = 4'hF;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (key_out !== 4'hF || key_press !== 4'h0 || key_release !== 4'h0) bad_rst++;
      end
      reset_n = 1'b1;
      repeat (60) begin
         @(posedge clk);
         #1;
         if (key_out !== 4'hF || key_press !== 4'h0 || key_release !== 4'h0) bad_post++;
      end
      n_assert++;
      if (bad_pre !== 0 || bad_rst !== 0 || bad_post !== 0) begin
         n_fail++;
         $display("FAIL reset_mid: bad cycles pre=%0d rst=%0d post=%0d, required all 0",
                  bad_pre, bad_rst, bad_post);
      end
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      key_raw  = 4'hF;
      test_reset();
      test_press_key0();
      test_bounce_key1();
      test_glitch_key2();
      test_release_key3();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
